// File: rtl/systolic_feed_ctrl_pkg.sv
// rtl/systolic_feed_ctrl_pkg.sv - shared states, latency constants and default widths
package systolic_feed_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DEF_N      = 4;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_K_W    = 8;

    // Operand memories return data one cycle after the read enable.
    localparam int RD_LAT = 1;

    // Read latency + edge skew + array traversal + final MAC.
    function automatic int drain_cycles(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/systolic_feed_ctrl_valid_skew_line.sv
// rtl/systolic_feed_ctrl_valid_skew_line.sv - registered delay line producing skewed per-lane valids
module valid_skew_line #(
    parameter int N   = 4,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         din,
    output logic [N-1:0] lane_valid
);

    localparam int DEPTH = N + LAT - 1;

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[DEPTH-2:0], din};
        end
    end

    // Lane 0 sits LAT cycles behind the read enable; each further lane adds one.
    assign lane_valid = sr[DEPTH-1:LAT-1];

endmodule

// File: rtl/systolic_feed_ctrl.sv
// rtl/systolic_feed_ctrl.sv - sequences clear, operand feed and drain for one systolic pass
module systolic_feed_ctrl
    import systolic_feed_ctrl_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int K_W    = DEF_K_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [K_W-1:0]    k_len,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    output logic              busy,
    output logic              done,
    output logic              acc_clear,
    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_rd_addr,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] b_rd_addr,
    output logic [N-1:0]      lane_valid
);

    localparam int DRAIN_N = drain_cycles(N);
    localparam int DW      = $clog2(DRAIN_N);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_N - 1);

    state_t            state;
    logic [K_W-1:0]    k_reg;
    logic [K_W-1:0]    beat;
    logic [ADDR_W-1:0] a_base_reg;
    logic [ADDR_W-1:0] b_base_reg;
    logic [DW-1:0]     drain_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            k_reg      <= '0;
            beat       <= '0;
            a_base_reg <= '0;
            b_base_reg <= '0;
            drain_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            acc_clear  <= 1'b0;
            a_rd_en    <= 1'b0;
            b_rd_en    <= 1'b0;
            a_rd_addr  <= '0;
            b_rd_addr  <= '0;
        end else begin
            done      <= 1'b0;
            acc_clear <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        k_reg      <= k_len;
                        a_base_reg <= a_base;
                        b_base_reg <= b_base;
                        busy       <= 1'b1;
                        if (k_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= CLEAR;
                            acc_clear <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    beat      <= '0;
                    a_rd_en   <= 1'b1;
                    b_rd_en   <= 1'b1;
                    a_rd_addr <= a_base_reg;
                    b_rd_addr <= b_base_reg;
                    state     <= FEED;
                end
                FEED: begin
                    // beat indexes the read currently on the bus; it never exceeds k_len-1.
                    if (beat == k_reg - 1'b1) begin
                        a_rd_en   <= 1'b0;
                        b_rd_en   <= 1'b0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        beat      <= beat + 1'b1;
                        a_rd_addr <= a_rd_addr + 1'b1;
                        b_rd_addr <= b_rd_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    valid_skew_line #(
        .N   (N),
        .LAT (RD_LAT)
    ) u_skew (
        .clk        (clk),
        .rst        (rst),
        .din        (a_rd_en),
        .lane_valid (lane_valid)
    );

endmodule
